// File: rtl/zone_winner_stream.sv
// zone_winner_stream: captures a 4-zone x 3-slot set of (key_ph index, rank)
// winners and streams the non-empty ones out one per handshake, highest rank
// first, ties resolved by lowest zone then lowest slot.
//
// Each winner takes two cycles in SEL: the first registers the 12-way
// arbitration result, the second loads the chosen entry into out_*.
// Splitting it this way keeps the rank comparator chain off the output path.
module zone_winner_stream #(
  parameter int bwr  = 6,  // rank width
  parameter int bpow = 7   // key_ph index MSB; index width is bpow+1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0][2:0][bpow:0]      ph_num,
  input  logic [3:0][2:0][bwr-1:0]     ph_q,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   out_zone,
  output logic [1:0]                   out_slot,
  output logic [bpow:0]                out_num,
  output logic [bwr-1:0]               out_q,
  output logic                         out_last
);

  localparam int N_ENT = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Captured set, flattened as index = zone*3 + slot.
  logic [bpow:0]    ent_num [N_ENT];
  logic [bwr-1:0]   ent_q   [N_ENT];
  logic [N_ENT-1:0] pending;

  // SEL sub-phase: 0 = arbitrate, 1 = load output register.
  logic sel_phase;

  // Registered arbitration result.
  logic       win_any;
  logic       win_single;
  logic [1:0] win_zone;
  logic [1:0] win_slot;
  logic [3:0] win_idx;

  // Combinational arbitration over the pending entries.
  logic           arb_any;
  logic           arb_single;
  logic [1:0]     arb_zone;
  logic [1:0]     arb_slot;
  logic [3:0]     arb_idx;
  logic [bwr-1:0] arb_q;

  // FSM control strobes.
  logic do_capture;
  logic do_arb;
  logic do_load;
  logic do_retire;

  // Pick the highest pending rank; strict '>' keeps the earliest
  // (lowest zone, then lowest slot) entry on a tie.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    arb_any  = 1'b0;
    arb_zone = 2'd0;
    arb_slot = 2'd0;
    arb_idx  = 4'd0;
    arb_q    = '0;
    for (int z = 0; z < 4; z++) begin
      for (int s = 0; s < 3; s++) begin
        if (pending[z*3+s] && (!arb_any || (ent_q[z*3+s] > arb_q))) begin
          arb_any  = 1'b1;
          arb_zone = 2'(z);
          arb_slot = 2'(s);
          arb_idx  = 4'(z*3 + s);
          arb_q    = ent_q[z*3+s];
        end
      end
    end
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    arb_single = (pending != '0) && ((pending & (pending - 12'd1)) == '0);
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt  = state;
    do_capture = 1'b0;
    do_arb     = 1'b0;
    do_load    = 1'b0;
    do_retire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          do_capture = 1'b1;
          state_nxt  = SEL;
        end
      end
      SEL: begin
        if (!sel_phase) begin
          do_arb = 1'b1;
        end else if (!win_any) begin
          state_nxt = IDLE;
        end else begin
          do_load   = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          do_retire = 1'b1;
          state_nxt = out_last ? IDLE : SEL;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, SEL sub-phase and registered in_ready.
  // NOTE: sequential blocks use non-blocking '<=' so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_phase <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel_phase <= do_arb;
      in_ready  <= (state_nxt == IDLE);
    end
  end

  // Entry buffer: written only on capture.
  // NOTE: the buffer is deliberately not reset; its contents are only ever read behind a pending bit, which is reset.
  always_ff @(posedge clk) begin
    if (do_capture) begin
      for (int z = 0; z < 4; z++) begin
        for (int s = 0; s < 3; s++) begin
          ent_num[z*3+s] <= ph_num[z][s];
          ent_q[z*3+s]   <= ph_q[z][s];
        end
      end
    end
  end

  // Pending bits: loaded on capture, cleared one at a time as winners retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (do_capture) begin
      for (int z = 0; z < 4; z++) begin
        for (int s = 0; s < 3; s++) begin
          pending[z*3+s] <= (ph_q[z][s] != '0);
        end
      end
    end else if (do_retire) begin
      pending[win_idx] <= 1'b0;
    end
  end

  // Arbitration result register, held through the load and EMIT phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_any    <= 1'b0;
      win_single <= 1'b0;
      win_zone   <= 2'd0;
      win_slot   <= 2'd0;
      win_idx    <= 4'd0;
    end else if (do_arb) begin
      win_any    <= arb_any;
      win_single <= arb_single;
      win_zone   <= arb_zone;
      win_slot   <= arb_slot;
      win_idx    <= arb_idx;
    end
  end

  // Output register: loaded from the chosen entry, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_zone  <= 2'd0;
      out_slot  <= 2'd0;
      out_num   <= '0;
      out_q     <= '0;
    end else if (do_load) begin
      out_valid <= 1'b1;
      out_last  <= win_single;
      out_zone  <= win_zone;
      out_slot  <= win_slot;
      out_num   <= ent_num[win_idx];
      out_q     <= ent_q[win_idx];
    end else if (do_retire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zone_winner_stream.sv
// Directed bench for zone_winner_stream. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_zone_winner_stream;

  localparam int BWR  = 6;
  localparam int BPOW = 7;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [3:0][2:0][BPOW:0]  ph_num;
  logic [3:0][2:0][BWR-1:0] ph_q;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [1:0]               out_zone;
  logic [1:0]               out_slot;
  logic [BPOW:0]            out_num;
  logic [BWR-1:0]           out_q;
  logic                     out_last;

  int vectors     = 0;
  int miscompares = 0;

  zone_winner_stream #(.bwr(BWR), .bpow(BPOW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ph_num    (ph_num),
    .ph_q      (ph_q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_zone  (out_zone),
    .out_slot  (out_slot),
    .out_num   (out_num),
    .out_q     (out_q),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Beat word: {valid, zone, slot, num, q, last}
  typedef logic [1+2+2+(BPOW+1)+BWR+1-1:0] beat_t;

  function automatic beat_t mk_beat(int v, int z, int s, int n, int q, int l);
    beat_t b;
    b = {v[0], z[1:0], s[1:0], n[BPOW:0], q[BWR-1:0], l[0]};
    return b;
  endfunction

  beat_t cur_beat;
  assign cur_beat = {out_valid, out_zone, out_slot, out_num, out_q, out_last};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_set();
    ph_num = '0;
    ph_q   = '0;
  endtask

  task automatic put(int z, int s, int n, int q);
    ph_num[z][s] = n[BPOW:0];
    ph_q[z][s]   = q[BWR-1:0];
  endtask

  task automatic capture();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({in_ready, cur_beat} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0", {in_ready, cur_beat});
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_early: in_ready got %b expected 0", in_ready);
    end
    tick();
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_first_edge: {in_ready,out_valid} got %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_single();
    clear_set();
    put(2, 1, 100, 45);
    out_ready = 1'b1;
    capture();
    vectors++;
    if ({in_ready, out_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_n0: {in_ready,out_valid} got %b expected 00", {in_ready, out_valid});
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_n1: out_valid got %b expected 0", out_valid);
    end
    tick();
    vectors++;
    if (cur_beat !== mk_beat(1, 2, 1, 100, 45, 1)) begin
      miscompares++;
      $display("FAIL single_beat: got %h expected %h", cur_beat, mk_beat(1, 2, 1, 100, 45, 1));
    end
    tick();
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_done: {in_ready,out_valid} got %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_all_zero();
    clear_set();
    capture();
    tick();
    vectors++;
    if ({in_ready, out_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_n1: {in_ready,out_valid} got %b expected 00", {in_ready, out_valid});
    end
    tick();
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL zero_n2: {in_ready,out_valid} got %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_order();
    beat_t exp_beats [3];
    int    k;
    exp_beats[0] = mk_beat(1, 1, 0, 33, 63, 0);
    exp_beats[1] = mk_beat(1, 3, 2, 22, 63, 0);
    exp_beats[2] = mk_beat(1, 0, 0, 11, 10, 1);
    clear_set();
    put(0, 0, 11, 10);
    put(3, 2, 22, 63);
    put(1, 0, 33, 63);
    out_ready = 1'b1;
    capture();
    k = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c % 3 == 2) begin
        vectors++;
        if (cur_beat !== exp_beats[k]) begin
          miscompares++;
          $display("FAIL order_beat%0d: got %h expected %h", k, cur_beat, exp_beats[k]);
        end
        k++;
      end else begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL order_gap_c%0d: out_valid got %b expected 0", c, out_valid);
        end
      end
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL order_done: in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_stall();
    clear_set();
    put(0, 1, 7, 20);
    put(2, 0, 9, 30);
    out_ready = 1'b0;
    capture();
    tick();
    tick();
    vectors++;
    if (cur_beat !== mk_beat(1, 2, 0, 9, 30, 0)) begin
      miscompares++;
      $display("FAIL stall_beat1: got %h expected %h", cur_beat, mk_beat(1, 2, 0, 9, 30, 0));
    end
    for (int i = 0; i < 20; i++) begin
      for (int z = 0; z < 4; z++)
        for (int s = 0; s < 3; s++)
          put(z, s, 255, 63);
      in_valid = (i % 2 == 0);
      tick();
      vectors++;
      if ({in_ready, cur_beat} !== {1'b0, mk_beat(1, 2, 0, 9, 30, 0)}) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got %h expected %h", i, {in_ready, cur_beat},
                 {1'b0, mk_beat(1, 2, 0, 9, 30, 0)});
      end
    end
    in_valid = 1'b0;
    clear_set();
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: out_valid got %b expected 0", out_valid);
    end
    tick();
    tick();
    vectors++;
    if (cur_beat !== mk_beat(1, 0, 1, 7, 20, 1)) begin
      miscompares++;
      $display("FAIL stall_beat2: got %h expected %h", cur_beat, mk_beat(1, 0, 1, 7, 20, 1));
    end
    tick();
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_done: {in_ready,out_valid} got %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid();
    clear_set();
    put(0, 0, 1, 40);
    put(1, 1, 2, 30);
    put(2, 2, 3, 20);
    out_ready = 1'b1;
    capture();
    for (int c = 1; c <= 5; c++) tick();
    vectors++;
    if (cur_beat !== mk_beat(1, 1, 1, 2, 30, 0)) begin
      miscompares++;
      $display("FAIL rstmid_beat2: got %h expected %h", cur_beat, mk_beat(1, 1, 1, 2, 30, 0));
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, out_last} !== 3'b000) begin
      miscompares++;
      $display("FAIL rstmid_async: {in_ready,out_valid,out_last} got %b expected 000",
               {in_ready, out_valid, out_last});
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL rstmid_stale_%0d: {in_ready,out_valid} got %b expected 10", c, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_random();
    int  mq [12];
    int  mn [12];
    bit  seen [12];
    int  beats;
    int  prev_q;
    int  idx;
    bit  done;
    clear_set();
    for (int z = 0; z < 4; z++) begin
      for (int s = 0; s < 3; s++) begin
        mq[z*3+s]   = int'($urandom_range(1, 63));
        mn[z*3+s]   = int'($urandom_range(0, 255));
        seen[z*3+s] = 1'b0;
        put(z, s, mn[z*3+s], mq[z*3+s]);
      end
    end
    out_ready = 1'b0;
    capture();
    beats  = 0;
    prev_q = 64;
    done   = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        beats++;
        idx = int'(out_zone) * 3 + int'(out_slot);
        vectors++;
        if (out_slot > 2'd2 || seen[idx]) begin
          miscompares++;
          $display("FAIL rand_unique_b%0d: zone %0d slot %0d repeated or invalid", beats, out_zone, out_slot);
        end else begin
          seen[idx] = 1'b1;
          vectors++;
          if ({out_num, out_q} !== {mn[idx][BPOW:0], mq[idx][BWR-1:0]}) begin
            miscompares++;
            $display("FAIL rand_data_b%0d: num/q got %0d/%0d expected %0d/%0d",
                     beats, out_num, out_q, mn[idx], mq[idx]);
          end
        end
        vectors++;
        if (int'(out_q) > prev_q) begin
          miscompares++;
          $display("FAIL rand_order_b%0d: q got %0d after %0d", beats, out_q, prev_q);
        end
        vectors++;
        if (out_last !== (beats == 12)) begin
          miscompares++;
          $display("FAIL rand_last_b%0d: last got %b expected %b", beats, out_last, beats == 12);
        end
        prev_q = int'(out_q);
        if (out_last) done = 1'b1;
      end
      tick();
    end
    out_ready = 1'b1;
    vectors++;
    if (!done || beats != 12) begin
      miscompares++;
      $display("FAIL rand_count: beats got %0d expected 12 (done=%0b)", beats, done);
    end
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL rand_done: {in_ready,out_valid} got %b expected 10", {in_ready, out_valid});
    end
  endtask

  initial begin
    clear_set();
    test_reset();
    test_single();
    test_all_zero();
    test_order();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
